// File: rtl/icache_2way_param.sv
// 2-way set-associative read-only instruction cache with per-set LRU,
// flush (fence.i) support and saturating hit/miss counters.
module icache_2way_param #(
  parameter int ADDR_W   = 30,
  parameter int SET_BITS = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic [ADDR_W-1:0] proc_addr,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  input  logic              flush,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [127:0]      mem_rdata,
  output logic [127:0]      mem_wdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_FILL} state_t;

  state_t              state_q, state_d;
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0]     lru_q, lru_d;        // way to evict next
  logic [TAG_W-1:0]    tag_q  [2][SETS];
  logic [TAG_W-1:0]    tag_d  [2][SETS];
  logic [127:0]        data_q [2][SETS];
  logic [127:0]        data_d [2][SETS];
  logic [127:0]        line_q, line_d;      // fill buffer
  logic                victim_q, victim_d;
  logic                flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic [1:0]          word;
  logic                hit0, hit1, hit, hit_way, victim;
  logic [127:0]        hit_line;

  assign set_idx = proc_addr[SET_BITS+1:2];
  assign tag_in  = proc_addr[ADDR_W-1:SET_BITS+2];
  assign word    = proc_addr[1:0];

  assign mem_addr  = proc_addr[ADDR_W-1:2];
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Tag lookup, word select and victim choice for the addressed set
  always_comb begin
    hit0       = proc_read & valid_q[0][set_idx] & (tag_q[0][set_idx] == tag_in);
    hit1       = proc_read & valid_q[1][set_idx] & (tag_q[1][set_idx] == tag_in);
    hit        = hit0 | hit1;
    hit_way    = ~hit0;
    hit_line   = hit0 ? data_q[0][set_idx] : data_q[1][set_idx];
    proc_rdata = hit ? hit_line[{word, 5'd0} +: 32] : 32'd0;
    if (!valid_q[0][set_idx])      victim = 1'b0;
    else if (!valid_q[1][set_idx]) victim = 1'b1;
    else                           victim = lru_q[set_idx];
  end

  // Next-state, array update and handshake outputs for the miss FSM
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    lru_d        = lru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    line_d       = line_q;
    victim_d     = victim_q;
    flush_pend_d = flush_pend_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    proc_stall   = 1'b0;
    mem_read     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // fence.i: hold the pipe one cycle while every line drops
          proc_stall = 1'b1;
          valid_d    = '0;
          lru_d      = '0;
        end else if (proc_read) begin
          if (hit) begin
            lru_d[set_idx] = ~hit_way;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            victim_d   = victim;
            state_d    = S_ALLOC;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          line_d  = mem_rdata;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        proc_stall                 = 1'b1;
        data_d[victim_q][set_idx]  = line_q;
        tag_d[victim_q][set_idx]   = tag_in;
        valid_d[victim_q][set_idx] = 1'b1;
        lru_d[set_idx]             = ~victim_q;
        state_d                    = S_IDLE;
        // A flush seen during the miss wipes everything, fresh line included
        if (flush_pend_q || flush) begin
          valid_d      = '0;
          lru_d        = '0;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      lru_q        <= '0;
      line_q       <= '0;
      victim_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          data_q[w][s] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      lru_q        <= lru_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      line_q       <= line_d;
      victim_q     <= victim_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_icache_2way_param.sv
// Bench for icache_2way_param: directed plan steps plus random fetch traffic,
// checked against a recency-ordered set model of resident lines.
module tb_icache_2way_param;
  localparam int ADDR_W = 30;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              proc_reset, proc_read, flush, mem_ready;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_rdata;
  logic              proc_stall, mem_read, mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [127:0]      mem_rdata, mem_wdata;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  icache_2way_param #(.ADDR_W(ADDR_W), .SET_BITS(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_addr(proc_addr),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: resident line address -> last-use timestamp
  int unsigned last_use [logic [27:0]];
  int unsigned tick = 0;
  int m_hit = 0, m_miss = 0;

  function automatic logic [31:0] word_of(logic [27:0] la, logic [1:0] w);
    return {4'hD, la[25:0], w};
  endfunction

  function automatic logic [127:0] line_data(logic [27:0] la);
    return {word_of(la, 2'd3), word_of(la, 2'd2), word_of(la, 2'd1), word_of(la, 2'd0)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  // Bring in a line: at most two per set, least recently used one leaves
  task automatic model_insert(input logic [27:0] la);
    int n = 0;
    int unsigned ot = 32'hFFFF_FFFF;
    logic [27:0] old = '0;
    foreach (last_use[k]) begin
      if (k[2:0] == la[2:0]) begin
        n++;
        if (last_use[k] < ot) begin ot = last_use[k]; old = k; end
      end
    end
    if (n >= 2) last_use.delete(old);
    tick++;
    last_use[la] = tick;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1; proc_read = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    last_use.delete();
    m_hit = 0; m_miss = 0;
  endtask

  // One fetch; on a miss memory answers on the lat-th ALLOCATE cycle
  task automatic do_read(input logic [29:0] a, input int lat, input bit fl_alloc,
                         output bit dut_hit);
    logic [27:0] la;
    bit mh;
    int sc;
    la = a[29:2];
    proc_read = 1'b1; proc_addr = a; #1;
    mh = last_use.exists(la);
    dut_hit = !proc_stall;
    chk("hit", dut_hit, mh);
    if (mh) begin
      chk("rdata", proc_rdata, word_of(la, a[1:0]));
      chk("mem_read_on_hit", mem_read, 0);
      tick++; last_use[la] = tick;
      if (m_hit < CMAX) m_hit++;
      @(posedge clk); #1;
    end else begin
      chk("mem_read_on_miss", mem_read, 1);
      chk("mem_addr", mem_addr, la);
      sc = int'(proc_stall);
      @(posedge clk); #1;
      for (int i = 1; i <= lat; i++) begin
        sc += int'(proc_stall);
        chk("mem_read_alloc", mem_read, 1);
        if (fl_alloc && i == 1) flush = 1'b1;
        if (i == lat) begin mem_ready = 1'b1; mem_rdata = line_data(la); end
        @(posedge clk); #1;
        mem_ready = 1'b0; flush = 1'b0; mem_rdata = {4{$urandom()}};
      end
      sc += int'(proc_stall);
      chk("mem_read_fill", mem_read, 0);
      mem_ready = 1'b1;  // stray ready during FILL must be ignored
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("stall_cycles", sc, lat + 2);
      model_insert(la);
      if (fl_alloc) last_use.delete();
      if (m_miss < CMAX) m_miss++;
    end
    chk_cnt();
  endtask

  task automatic idle_flush(input logic [29:0] a);
    proc_read = 1'b1; proc_addr = a; flush = 1'b1; #1;
    chk("flush_stall", proc_stall, 1);
    chk("flush_mem_read", mem_read, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    last_use.delete();
    chk_cnt();
  endtask

  task automatic no_read(input logic [29:0] a);
    proc_read = 1'b0; proc_addr = a; #1;
    chk("noread_stall", proc_stall, 0);
    chk("noread_mem_read", mem_read, 0);
    chk("noread_rdata", proc_rdata, 0);
    @(posedge clk); #1;
    chk_cnt();
  endtask

  initial begin
    bit h;
    logic [29:0] a;
    int r;
    proc_reset = 1'b1; proc_read = 1'b0; proc_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;

    // Reset state
    chk("rst_stall", proc_stall, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk_cnt();

    // First miss at 0x40, 3-cycle memory
    proc_read = 1'b1; proc_addr = 30'h40; #1;
    chk("plan_mem_addr", mem_addr, 28'h10);
    do_read(30'h40, 3, 0, h); chk("plan_first_miss", h, 0);
    chk("plan_miss_cnt", miss_cnt, 1);
    do_read(30'h40, 1, 0, h); chk("plan_d0_hit", h, 1);
    chk("plan_d0", proc_rdata, word_of(28'h10, 2'd0));
    do_read(30'h41, 1, 0, h); chk("plan_d1_hit", h, 1);
    chk("plan_hit_cnt", hit_cnt, 2);

    // Conflict and LRU replacement in set 0
    do_reset();
    do_read(30'h000, 2, 0, h); chk("cf_fill0", h, 0);
    do_read(30'h020, 2, 0, h); chk("cf_fill1", h, 0);
    do_read(30'h000, 1, 0, h); chk("cf_rehit", h, 1);
    do_read(30'h040, 2, 0, h); chk("cf_evict", h, 0);
    do_read(30'h000, 1, 0, h); chk("cf_keep", h, 1);
    do_read(30'h020, 2, 0, h); chk("cf_gone", h, 0);

    // Flush in IDLE, then flush during ALLOCATE
    idle_flush(30'h000);
    do_read(30'h000, 1, 0, h); chk("fl_idle_miss", h, 0);
    do_read(30'h004, 2, 1, h); chk("fl_alloc_first", h, 0);
    do_read(30'h004, 1, 0, h); chk("fl_alloc_remiss", h, 0);

    // No request with a miss address
    no_read(30'h3FC);

    // Reset in the middle of ALLOCATE, then a late mem_ready
    proc_read = 1'b1; proc_addr = 30'h180; #1;
    chk("rm_miss", proc_stall, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rm_alloc", mem_read, 1);
    do_reset();
    chk("rm_mem_read", mem_read, 0);
    chk("rm_stall", proc_stall, 0);
    chk_cnt();
    mem_ready = 1'b1; mem_rdata = line_data(28'h60);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("rm_late_ready", mem_read, 0);
    do_read(30'h004, 1, 0, h); chk("rm_valid_clr", h, 0);
    do_read(30'h180, 2, 0, h); chk("rm_refetch", h, 0);

    // Hit counter saturation
    for (int i = 0; i < 20; i++) do_read(30'h181, 1, 0, h);
    chk("sat_hit_cnt", hit_cnt, CMAX);

    // Random traffic over a few tags/sets
    do_reset();
    for (int i = 0; i < 250; i++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom())};
      r = $urandom_range(0, 19);
      if (r < 16)       do_read(a, $urandom_range(1, 4), ($urandom_range(0, 9) == 0), h);
      else if (r < 18)  idle_flush(a);
      else              no_read(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
